// File: rtl/fetch.sv
// Instruction fetch for the CHIP-8 core: reads each big-endian 16-bit instruction
// from byte-wide memory and holds it at the output until execute accepts it.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ADDR_HI | issue read of hi byte at pc (or trap when pc is 12'hFFF)
// ADDR_LO | issue read of lo byte at pc+1, capture hi byte
// CAP_LO  | capture lo byte
// PRESENT | instruction valid, wait for accept (not stalled)
// TRAP    | sticky fetch trap, left only through reset
module fetch #(
   parameter logic [11:0] RESET_PC = 12'h200
) (
   input  logic        clk,
   input  logic        rst,
   output logic [11:0] mem_addr,
   output logic        mem_rd,
   input  logic [7:0]  mem_rdata,
   input  logic        stalled,
   input  logic        branching,
   input  logic [11:0] branch_target,
   output logic [15:0] instruction,
   output logic [11:0] instr_pc,
   output logic        instr_valid,
   output logic        fetch_trap
);

   typedef enum logic [2:0] {
      ADDR_HI = 3'd0,
      ADDR_LO = 3'd1,
      CAP_LO  = 3'd2,
      PRESENT = 3'd3,
      TRAP    = 3'd4
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [11:0] pc;
   logic [7:0]  hi_reg;
   logic [7:0]  lo_reg;
   logic        accept;
   logic        rd_raw;

   assign accept = (state == PRESENT) && !stalled;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ADDR_HI;
      end else begin
         state <= state_nxt;
      end
   end

   // pc wraps naturally in 12 bits (12'hFFE + 2 = 12'h000)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc     <= RESET_PC;
         hi_reg <= 8'h00;
         lo_reg <= 8'h00;
      end else begin
         if (state == ADDR_LO) begin
            hi_reg <= mem_rdata;
         end
         if (state == CAP_LO) begin
            lo_reg <= mem_rdata;
         end
         if (accept) begin
            pc <= branching ? branch_target : pc + 12'd2;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ADDR_HI: state_nxt = (pc == 12'hFFF) ? TRAP : ADDR_LO;
         ADDR_LO: state_nxt = CAP_LO;
         CAP_LO:  state_nxt = PRESENT;
         PRESENT: state_nxt = accept ? ADDR_HI : PRESENT;
         TRAP:    state_nxt = TRAP;
         default: state_nxt = ADDR_HI;
      endcase
   end

   always_comb begin
      rd_raw      = 1'b0;
      mem_addr    = pc;
      instr_valid = 1'b0;
      fetch_trap  = 1'b0;
      case (state)
         ADDR_HI: rd_raw = (pc != 12'hFFF);
         ADDR_LO: begin
            rd_raw   = 1'b1;
            mem_addr = pc + 12'd1;
         end
         PRESENT: instr_valid = 1'b1;
         TRAP:    fetch_trap  = 1'b1;
         default: rd_raw = 1'b0;
      endcase
   end

   // reset leaves the FSM in ADDR_HI, so the read strobe must be gated by rst itself
   assign mem_rd      = rd_raw & rst;
   assign instruction = {hi_reg, lo_reg};
   assign instr_pc    = pc;

endmodule
